// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary neural network layer engine.
// State encoding is kept as plain localparams for compatibility with older tools.
package bnn_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t DONE  = 2'd2;

   // Width of the signed neuron score: popcount width plus sign and doubling bits.
   function automatic int unsigned score_width(input int unsigned in_width);
      return $clog2(in_width + 1) + 2;
   endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Registered population count; the output register is the engine's only
// pipeline stage between the weight beat and the out_vec write.
module bnn_popcount #(
   parameter int unsigned WIDTH = 512,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] bits,
   output logic [CW-1:0]    count
);

   logic [CW-1:0] sum;

   // Plain reduction; synthesis rebalances it into an adder tree.
   always_comb begin
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum = sum + CW'(bits[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else begin
         count <= sum;
      end
   end

endmodule

// File: rtl/bnn_layer_engine.sv
// One binary neural network layer: XNOR-popcount plus bias and sign per weight beat,
// assembling the layer output vector and pulsing out_valid when it is complete.
module bnn_layer_engine
   import bnn_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = 512,
   parameter int unsigned NUM_NEURONS = 1024,
   parameter int unsigned BIAS_WIDTH  = 2,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IN_WIDTH-1:0]    act_in,
   input  logic                   act_valid,
   input  logic                   ren_in,
   input  logic [IN_WIDTH-1:0]    weight_in,
   input  logic [BIAS_WIDTH-1:0]  bias_in,
   output logic                   busy,
   output logic [NUM_NEURONS-1:0] out_vec,
   output logic                   out_valid
);

   localparam int unsigned PW = $clog2(IN_WIDTH + 1);
   localparam int unsigned SW = score_width(IN_WIDTH);
   localparam int unsigned CW = $clog2(NUM_NEURONS + 1);
   localparam int unsigned IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic signed [SW-1:0] IN_W = SW'(IN_WIDTH);

   state_t                state, state_next;
   logic [IN_WIDTH-1:0]   act_reg;
   logic [IN_WIDTH-1:0]   xnor_bits;
   logic [MEM_LATENCY-1:0] ren_dly;
   logic                  beat;
   logic                  take;
   logic [CW-1:0]         beat_cnt;
   logic                  pipe_vld;
   logic [IW-1:0]         pipe_idx;
   logic [BIAS_WIDTH-1:0] pipe_bias;
   logic [PW-1:0]         pc;
   logic signed [SW-1:0]  pc_ext, bias_ext, score;
   logic                  neuron_bit;

   assign beat      = ren_dly[MEM_LATENCY-1];
   assign take      = (state == ACCUM) && beat && (beat_cnt < CW'(NUM_NEURONS));
   assign xnor_bits = ~(act_reg ^ weight_in);

   bnn_popcount #(
      .WIDTH (IN_WIDTH),
      .CW    (PW)
   ) u_popcount (
      .clk   (clk),
      .rst   (rst),
      .bits  (xnor_bits),
      .count (pc)
   );

   // score = 2*pc - IN_WIDTH + bias; the neuron fires when score is non-negative
   always_comb begin
      pc_ext     = SW'(pc);
      bias_ext   = SW'($signed(pipe_bias));
      score      = (pc_ext <<< 1) - IN_W + bias_ext;
      neuron_bit = ~score[SW-1];
   end

   // DONE is entered on the same edge that writes the last neuron bit.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (act_valid) state_next = ACCUM;
         ACCUM:   if (beat_cnt == CW'(NUM_NEURONS)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         act_reg   <= '0;
         ren_dly   <= '0;
         beat_cnt  <= '0;
         pipe_vld  <= 1'b0;
         pipe_idx  <= '0;
         pipe_bias <= '0;
         out_vec   <= '0;
      end else begin
         state   <= state_next;
         ren_dly <= (ren_dly << 1) | MEM_LATENCY'(ren_in);
         if ((state == IDLE) && act_valid) begin
            act_reg  <= act_in;
            beat_cnt <= '0;
         end else if (take) begin
            beat_cnt <= beat_cnt + CW'(1);
         end
         pipe_vld  <= take;
         pipe_idx  <= beat_cnt[IW-1:0];
         pipe_bias <= bias_in;
         if (pipe_vld) begin
            out_vec[pipe_idx] <= neuron_bit;
         end
      end
   end

   assign busy      = (state == ACCUM);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Directed bench for bnn_layer_engine: a small 8x4 instance for hand-computed vectors
// and a default-sized instance checked against a behavioural neuron model.
module tb_bnn_layer_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [7:0]    act_s, weight_s;
   logic          act_valid_s, ren_s, busy_s, out_valid_s;
   logic [1:0]    bias_s;
   logic [3:0]    out_vec_s;

   logic [511:0]  act_l, weight_l;
   logic          act_valid_l, ren_l, busy_l, out_valid_l;
   logic [1:0]    bias_l;
   logic [1023:0] out_vec_l;

   bnn_layer_engine #(
      .IN_WIDTH    (8),
      .NUM_NEURONS (4),
      .BIAS_WIDTH  (2),
      .MEM_LATENCY (1)
   ) dut_s (
      .clk       (clk),
      .rst       (rst),
      .act_in    (act_s),
      .act_valid (act_valid_s),
      .ren_in    (ren_s),
      .weight_in (weight_s),
      .bias_in   (bias_s),
      .busy      (busy_s),
      .out_vec   (out_vec_s),
      .out_valid (out_valid_s)
   );

   bnn_layer_engine dut_l (
      .clk       (clk),
      .rst       (rst),
      .act_in    (act_l),
      .act_valid (act_valid_l),
      .ren_in    (ren_l),
      .weight_in (weight_l),
      .bias_in   (bias_l),
      .busy      (busy_l),
      .out_vec   (out_vec_l),
      .out_valid (out_valid_l)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulses_s = 0;
   int pulses_l = 0;
   int valid_cyc_s = 0;
   int first_ren_cyc_s = -1;
   logic busy_at_valid_s = 1'b1;

   logic [7:0]   wv [8];
   logic [1:0]   bv [8];
   logic [511:0] wl [1024];
   logic [1:0]   bl [1024];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid_s) begin
         pulses_s++;
         valid_cyc_s = cyc;
         busy_at_valid_s = busy_s;
      end
      if (out_valid_l) pulses_l++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic arm_s(input logic [7:0] a);
      act_s = a;
      act_valid_s = 1'b1;
      tick();
      act_valid_s = 1'b0;
      act_s = 8'h3C;
   endtask

   // Drives ren per ren_pat bit; weight/bias follow each ren by one cycle.
   task automatic stream_s(input int ncyc, input logic [15:0] ren_pat, input int inj_cyc,
                           input logic [7:0] inj_act);
      int k = 0;
      logic prev = 1'b0;
      for (int c = 0; c < ncyc + 1; c++) begin
         ren_s = (c < ncyc) ? ren_pat[c] : 1'b0;
         if (ren_s && first_ren_cyc_s < 0) first_ren_cyc_s = cyc;
         if (prev) begin
            weight_s = wv[k];
            bias_s = bv[k];
            k++;
         end else begin
            weight_s = 8'hA5;
            bias_s = 2'b01;
         end
         act_valid_s = (c == inj_cyc);
         if (c == inj_cyc) act_s = inj_act;
         prev = ren_s;
         tick();
      end
      ren_s = 1'b0;
      act_valid_s = 1'b0;
      weight_s = 8'hA5;
   endtask

   task automatic load_base_vectors();
      wv[0] = 8'hFF; wv[1] = 8'h00; wv[2] = 8'hF0; wv[3] = 8'h0F;
      wv[4] = 8'h00; wv[5] = 8'h00; wv[6] = 8'h00; wv[7] = 8'h00;
      bv[0] = 2'b00; bv[1] = 2'b00; bv[2] = 2'b00; bv[3] = 2'b11;
      bv[4] = 2'b00; bv[5] = 2'b00; bv[6] = 2'b00; bv[7] = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle(2);
      checks++;
      if (busy_s !== 1'b0) begin
         errors++; $display("FAIL reset_busy got=%b exp=0", busy_s);
      end
      checks++;
      if (out_valid_s !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_s);
      end
      checks++;
      if (out_vec_s !== 4'b0000) begin
         errors++; $display("FAIL reset_out_vec got=%b exp=0000", out_vec_s);
      end
      checks++;
      if (out_vec_l !== '0 || busy_l !== 1'b0) begin
         errors++; $display("FAIL reset_large got_busy=%b exp_busy=0 out_vec_nonzero=%b",
                            busy_l, |out_vec_l);
      end
      rst = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      load_base_vectors();
      pulses_s = 0;
      first_ren_cyc_s = -1;
      arm_s(8'hFF);
      checks++;
      if (busy_s !== 1'b1) begin
         errors++; $display("FAIL basic_busy_armed got=%b exp=1", busy_s);
      end
      stream_s(4, 16'h000F, -1, 8'h00);
      idle(8);
      checks++;
      if (out_vec_s !== 4'b0101) begin
         errors++; $display("FAIL basic_out_vec got=%b exp=0101", out_vec_s);
      end
      checks++;
      if (pulses_s != 1) begin
         errors++; $display("FAIL basic_pulses got=%0d exp=1", pulses_s);
      end
      checks++;
      if (valid_cyc_s - first_ren_cyc_s != 6) begin
         errors++; $display("FAIL basic_latency got=%0d exp=6", valid_cyc_s - first_ren_cyc_s);
      end
      checks++;
      if (busy_at_valid_s !== 1'b0) begin
         errors++; $display("FAIL basic_busy_at_valid got=%b exp=0", busy_at_valid_s);
      end
      checks++;
      if (busy_s !== 1'b0) begin
         errors++; $display("FAIL basic_busy_after got=%b exp=0", busy_s);
      end
   endtask

   task automatic test_mid_reset();
      load_base_vectors();
      pulses_s = 0;
      arm_s(8'hFF);
      ren_s = 1'b1; weight_s = 8'hA5; bias_s = 2'b01;
      tick();
      ren_s = 1'b1; weight_s = wv[0]; bias_s = bv[0];
      tick();
      ren_s = 1'b0; weight_s = wv[1]; bias_s = bv[1];
      tick();
      rst = 1'b0; weight_s = 8'hA5;
      tick();
      checks++;
      if (out_vec_s !== 4'b0000) begin
         errors++; $display("FAIL midrst_out_vec got=%b exp=0000", out_vec_s);
      end
      checks++;
      if (busy_s !== 1'b0) begin
         errors++; $display("FAIL midrst_busy got=%b exp=0", busy_s);
      end
      rst = 1'b1;
      idle(10);
      checks++;
      if (pulses_s != 0) begin
         errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses_s);
      end
      first_ren_cyc_s = -1;
      arm_s(8'h00);
      stream_s(4, 16'h000F, -1, 8'h00);
      idle(8);
      checks++;
      if (out_vec_s !== 4'b0110) begin
         errors++; $display("FAIL midrst_restart_out_vec got=%b exp=0110", out_vec_s);
      end
      checks++;
      if (pulses_s != 1) begin
         errors++; $display("FAIL midrst_restart_pulses got=%0d exp=1", pulses_s);
      end
   endtask

   task automatic test_gap();
      load_base_vectors();
      pulses_s = 0;
      first_ren_cyc_s = -1;
      arm_s(8'hFF);
      stream_s(7, 16'h0063, -1, 8'h00);
      idle(8);
      checks++;
      if (out_vec_s !== 4'b0101) begin
         errors++; $display("FAIL gap_out_vec got=%b exp=0101", out_vec_s);
      end
      checks++;
      if (pulses_s != 1) begin
         errors++; $display("FAIL gap_pulses got=%0d exp=1", pulses_s);
      end
      checks++;
      if (valid_cyc_s - first_ren_cyc_s != 9) begin
         errors++; $display("FAIL gap_latency got=%0d exp=9", valid_cyc_s - first_ren_cyc_s);
      end
   endtask

   task automatic test_over_read();
      load_base_vectors();
      pulses_s = 0;
      first_ren_cyc_s = -1;
      arm_s(8'h00);
      stream_s(6, 16'h003F, -1, 8'h00);
      idle(10);
      checks++;
      if (out_vec_s !== 4'b0110) begin
         errors++; $display("FAIL overread_out_vec got=%b exp=0110", out_vec_s);
      end
      checks++;
      if (pulses_s != 1) begin
         errors++; $display("FAIL overread_pulses got=%0d exp=1", pulses_s);
      end
   endtask

   task automatic test_act_ignored();
      load_base_vectors();
      pulses_s = 0;
      first_ren_cyc_s = -1;
      arm_s(8'hFF);
      stream_s(4, 16'h000F, 2, 8'h00);
      idle(8);
      checks++;
      if (out_vec_s !== 4'b0101) begin
         errors++; $display("FAIL act_ignored_out_vec got=%b exp=0101", out_vec_s);
      end
      checks++;
      if (pulses_s != 1) begin
         errors++; $display("FAIL act_ignored_pulses got=%0d exp=1", pulses_s);
      end
   endtask

   task automatic test_large();
      logic [511:0]  a;
      logic [511:0]  w;
      logic [1023:0] exp_vec;
      logic          prev;
      int            issued, k, pc, b, score, ndiff, first_diff;
      for (int j = 0; j < 16; j++) a[j*32 +: 32] = $urandom();
      for (int i = 0; i < 1024; i++) begin
         for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom();
         wl[i] = w;
         bl[i] = 2'($urandom_range(0, 3));
         pc = $countones(~(a ^ w));
         b = $signed(bl[i]);
         score = 2 * pc - 512 + b;
         exp_vec[i] = (score >= 0);
      end
      pulses_l = 0;
      act_l = a;
      act_valid_l = 1'b1;
      tick();
      act_valid_l = 1'b0;
      act_l = ~a;
      issued = 0;
      k = 0;
      prev = 1'b0;
      for (int c = 0; c < 1400; c++) begin
         if (issued == 1024 && !prev) break;
         ren_l = (issued < 1024) && (c % 7 != 6);
         if (ren_l) issued++;
         if (prev) begin
            weight_l = wl[k];
            bias_l = bl[k];
            k++;
         end else begin
            weight_l = '1;
            bias_l = 2'b01;
         end
         prev = ren_l;
         tick();
      end
      ren_l = 1'b0;
      idle(10);
      ndiff = 0;
      first_diff = -1;
      for (int i = 0; i < 1024; i++) begin
         if (out_vec_l[i] !== exp_vec[i]) begin
            ndiff++;
            if (first_diff < 0) first_diff = i;
         end
      end
      checks++;
      if (out_vec_l !== exp_vec) begin
         errors++;
         $display("FAIL large_out_vec differing_bits=%0d (exp 0) first_idx=%0d got=%b exp=%b",
                  ndiff, first_diff, (first_diff >= 0) ? out_vec_l[first_diff] : 1'bx,
                  (first_diff >= 0) ? exp_vec[first_diff] : 1'bx);
      end
      checks++;
      if (pulses_l != 1) begin
         errors++; $display("FAIL large_pulses got=%0d exp=1", pulses_l);
      end
      checks++;
      if (busy_l !== 1'b0) begin
         errors++; $display("FAIL large_busy_after got=%b exp=0", busy_l);
      end
   endtask

   initial begin
      rst = 1'b1;
      act_s = '0; act_valid_s = 1'b0; ren_s = 1'b0; weight_s = '0; bias_s = '0;
      act_l = '0; act_valid_l = 1'b0; ren_l = 1'b0; weight_l = '0; bias_l = '0;
      #1;
      test_reset();
      test_basic();
      test_mid_reset();
      test_gap();
      test_over_read();
      test_act_ignored();
      test_large();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_layer_engine.md
Name: bnn_layer_engine

Overview:
- Consumer end of the layer weight/bias read stream: receives the per-neuron weight and bias words that the layer controller reads out of parameter memory.
- Evaluates one binary neuron per beat using XNOR-popcount plus bias, then sign.
- Assembles the layer's output bit-vector and pulses out_valid; that pulse drives the controller's next-layer trigger (valid_1 / valid_2).
- One instance per layer (L1/L2/L3), parameterised per layer.

Parameters:
- IN_WIDTH, 512, activation width; equals the layer's weight word width.
- NUM_NEURONS, 1024, neurons per layer; equals output vector width.
- BIAS_WIDTH, 2, signed two's-complement bias width.
- MEM_LATENCY, 1, cycles from weight/bias ren to data on weight_in/bias_in (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- act_in  in  IN_WIDTH  binary input activations (1 = +1, 0 = −1)
- act_valid  in  1  one-cycle strobe; captures act_in and arms the engine
- ren_in  in  1  weight/bias read-enable issued by the controller (weight_ren_lN)
- weight_in  in  IN_WIDTH  weight word for the current neuron (controller weight_out_lN)
- bias_in  in  BIAS_WIDTH  bias for the current neuron (controller bias_out_lN)
- busy  out  1  high from act_valid acceptance until out_valid
- out_vec  out  NUM_NEURONS  layer output bits; bit i = neuron i
- out_valid  out  1  one-cycle pulse when out_vec is complete

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, busy=0, out_valid=0, out_vec=0, activation reg=0, beat counter=0, ren delay line cleared. Reset mid-layer abandons the layer; no out_valid is produced.
- Beat qualification: beat = ren_in delayed by exactly MEM_LATENCY cycles (shift register). Data on weight_in/bias_in is sampled only on a beat cycle.
- States:
  - IDLE: act_valid=1 → latch act_in, beat_cnt=0, busy=1, go ARMED. Beats arriving in IDLE are ignored.
  - ARMED/ACCUM: each beat with beat_cnt < NUM_NEURONS evaluates neuron beat_cnt, then beat_cnt++. Gaps in ren_in (beat=0) stall without error. Beats with beat_cnt ≥ NUM_NEURONS are ignored; the controller over-reads past the last neuron. When beat_cnt reaches NUM_NEURONS, go DONE.
  - DONE: exactly one cycle with out_valid=1 and busy=0 in the same cycle, then IDLE.
- act_valid while not IDLE is ignored; the latched activation is held.
- act_valid in the DONE cycle is ignored.
- Neuron arithmetic:
  - pc = popcount(~(act ^ weight_in)), width $clog2(IN_WIDTH+1).
  - score = 2·pc − IN_WIDTH + sign_extend(bias_in), signed, width $clog2(IN_WIDTH+1)+2.
  - bit = (score ≥ 0).
- Pipeline: one register stage after popcount. out_vec[idx] is written 1 cycle after its beat. The last bit is written in the same cycle the FSM enters DONE, so out_vec is stable when out_valid=1.
- out_vec holds its value until the next layer's first write. Bits not yet written in a new layer retain old values; consumers use only out_valid.

Decomposition:
- Shared package bnn_pkg: state enum type (IDLE, ACCUM, DONE) and a signed score-width function.
- One sub-module: bnn_popcount, parameterised on width. It is a registered adder tree whose output register is the single pipeline stage.

Test Plan (small config IN_WIDTH=8, NUM_NEURONS=4, MEM_LATENCY=1 unless noted):
- act=8'hFF, 4 contiguous ren beats, weights FF,00,F0,0F, biases 0,0,0,−1 → scores +8,−8,0,−1 → out_vec=4'b0101. out_valid pulses once, MEM_LATENCY+NUM_NEURONS+1 cycles after first ren.
- Same as above, but ren deasserted 3 cycles between beats 2 and 3 → identical out_vec; out_valid delayed by 3 cycles.
- Controller-style over-read: 6 ren cycles (2 extra), extra weights 00 → out_vec unchanged, exactly one out_valid pulse.
- Second act_valid during ACCUM with different act_in → ignored; result matches the first activation.
- rst=0 asserted after beat 2 → out_vec=0, busy=0, no out_valid. A fresh act_valid plus 4 beats then completes normally.
- Defaults (512/1024), random act/weights/biases → out_vec matches the reference model bit-exact; out_valid pulse count = 1.
